// File: rtl/ram_arb_pkg.sv
// Shared types and default widths for the data-RAM arbiter.
package ram_arb_pkg;

  localparam int unsigned DEF_ADDR_W = 12;
  localparam int unsigned DEF_DATA_W = 4;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StDone   = 2'd2
  } state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } owner_e;

endpackage

// File: rtl/arb_wait_counter.sv
// Saturating starvation counter; clear wins over increment.
module arb_wait_counter #(
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned CNT_W    = $clog2(MAX_WAIT + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] count_q, count_d;

  // Next count: clear, saturating increment, or hold.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != CntMax)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/ram_arbiter.sv
// Two-port arbiter for the shared data RAM: CPU has priority unless the
// debug port has waited MAX_WAIT cycles. Each access is IDLE, ACCESS x N, DONE.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W        = DEF_ADDR_W,
  parameter int unsigned DATA_W        = DEF_DATA_W,
  parameter int unsigned ACCESS_CYCLES = 2,
  parameter int unsigned MAX_WAIT      = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_done,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_done,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              ram_cs,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);

  localparam int unsigned CntW  = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam int unsigned WaitW = $clog2(MAX_WAIT + 1);
  localparam logic [CntW-1:0]  CntLoad = CntW'(ACCESS_CYCLES - 1);
  localparam logic [WaitW-1:0] WaitMax = WaitW'(MAX_WAIT);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              cpu_gnt_q, cpu_gnt_d, dbg_gnt_q, dbg_gnt_d;
  logic              cpu_done_q, cpu_done_d, dbg_done_q, dbg_done_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d, dbg_rdata_q, dbg_rdata_d;
  logic              ram_cs_q, ram_cs_d, ram_we_q, ram_we_d;
  logic              busy_q, busy_d;
  logic              cpu_grant, dbg_grant;
  logic [WaitW-1:0]  dbg_wait;
  logic              wait_inc, wait_clr;

  // Debug starvation tracking: counts while debug waits and is not being served.
  assign wait_inc = dbg_req && !((state_q != StIdle) && (owner_q == OWN_DBG));
  assign wait_clr = !dbg_req || dbg_grant;

  arb_wait_counter #(
    .MAX_WAIT (MAX_WAIT),
    .CNT_W    (WaitW)
  ) u_wait_counter (
    .clock (clock),
    .reset (reset),
    .inc   (wait_inc),
    .clr   (wait_clr),
    .count (dbg_wait)
  );

  // Next-state and next-output logic; outputs are computed one cycle ahead.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    cpu_gnt_d   = cpu_gnt_q;
    dbg_gnt_d   = dbg_gnt_q;
    cpu_done_d  = 1'b0;
    dbg_done_d  = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;
    ram_cs_d    = ram_cs_q;
    ram_we_d    = ram_we_q;
    busy_d      = busy_q;
    cpu_grant   = 1'b0;
    dbg_grant   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (dbg_req && (dbg_wait == WaitMax)) begin
          dbg_grant = 1'b1;
        end else if (cpu_req) begin
          cpu_grant = 1'b1;
        end else if (dbg_req) begin
          dbg_grant = 1'b1;
        end
        if (cpu_grant || dbg_grant) begin
          owner_d   = dbg_grant ? OWN_DBG : OWN_CPU;
          we_d      = dbg_grant ? dbg_we : cpu_we;
          addr_d    = dbg_grant ? dbg_addr : cpu_addr;
          wdata_d   = dbg_grant ? dbg_wdata : cpu_wdata;
          cnt_d     = CntLoad;
          cpu_gnt_d = cpu_grant;
          dbg_gnt_d = dbg_grant;
          ram_cs_d  = 1'b1;
          ram_we_d  = we_d;
          busy_d    = 1'b1;
          state_d   = StAccess;
        end
      end
      StAccess: begin
        if (cnt_q == '0) begin
          // Last access cycle: ram_rdata is valid for the latched address.
          if (!we_q) begin
            if (owner_q == OWN_DBG) begin
              dbg_rdata_d = ram_rdata;
            end else begin
              cpu_rdata_d = ram_rdata;
            end
          end
          cpu_gnt_d  = 1'b0;
          dbg_gnt_d  = 1'b0;
          ram_cs_d   = 1'b0;
          ram_we_d   = 1'b0;
          cpu_done_d = (owner_q == OWN_CPU);
          dbg_done_d = (owner_q == OWN_DBG);
          state_d    = StDone;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StDone: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and registered outputs; reset clears everything.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      owner_q     <= OWN_CPU;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      cpu_gnt_q   <= 1'b0;
      dbg_gnt_q   <= 1'b0;
      cpu_done_q  <= 1'b0;
      dbg_done_q  <= 1'b0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
      ram_cs_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      cpu_gnt_q   <= cpu_gnt_d;
      dbg_gnt_q   <= dbg_gnt_d;
      cpu_done_q  <= cpu_done_d;
      dbg_done_q  <= dbg_done_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
      ram_cs_q    <= ram_cs_d;
      ram_we_q    <= ram_we_d;
      busy_q      <= busy_d;
    end
  end

  assign cpu_gnt   = cpu_gnt_q;
  assign dbg_gnt   = dbg_gnt_q;
  assign cpu_done  = cpu_done_q;
  assign dbg_done  = dbg_done_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dbg_rdata = dbg_rdata_q;
  assign ram_cs    = ram_cs_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural 4096x4 RAM on the bus.
module tb_ram_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, dbg_req, dbg_we;
  logic [11:0] cpu_addr, dbg_addr;
  logic [3:0]  cpu_wdata, dbg_wdata;
  logic        cpu_gnt, cpu_done, dbg_gnt, dbg_done;
  logic [3:0]  cpu_rdata, dbg_rdata;
  logic        ram_cs, ram_we, busy;
  logic [11:0] ram_addr;
  logic [3:0]  ram_wdata, ram_rdata;

  int vectors = 0;
  int miscompares = 0;

  logic [3:0] mem [4096];

  always #5 clock = ~clock;

  ram_arbiter dut (
    .clock     (clock),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_gnt   (cpu_gnt),
    .cpu_done  (cpu_done),
    .cpu_rdata (cpu_rdata),
    .dbg_req   (dbg_req),
    .dbg_we    (dbg_we),
    .dbg_addr  (dbg_addr),
    .dbg_wdata (dbg_wdata),
    .dbg_gnt   (dbg_gnt),
    .dbg_done  (dbg_done),
    .dbg_rdata (dbg_rdata),
    .ram_cs    (ram_cs),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .busy      (busy)
  );

  // Behavioural RAM: synchronous write, asynchronous read.
  always @(posedge clock) begin
    if (ram_cs && ram_we) mem[ram_addr] <= ram_wdata;
  end
  assign ram_rdata = mem[ram_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  // Checks the combined bus/handshake picture for one cycle.
  task automatic chk_bus(input string tag, input logic cs, input logic we, input logic cg,
                         input logic dg, input logic cd, input logic dd, input logic bz);
    chk({tag, ".ram_cs"}, 32'(ram_cs), 32'(cs));
    chk({tag, ".ram_we"}, 32'(ram_we), 32'(we));
    chk({tag, ".cpu_gnt"}, 32'(cpu_gnt), 32'(cg));
    chk({tag, ".dbg_gnt"}, 32'(dbg_gnt), 32'(dg));
    chk({tag, ".cpu_done"}, 32'(cpu_done), 32'(cd));
    chk({tag, ".dbg_done"}, 32'(dbg_done), 32'(dd));
    chk({tag, ".busy"}, 32'(busy), 32'(bz));
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 4'h0;
    reset = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
    tick(); tick();
    chk_bus("reset", 0, 0, 0, 0, 0, 0, 0);
    chk("reset.cpu_rdata", 32'(cpu_rdata), 32'h0);
    chk("reset.dbg_rdata", 32'(dbg_rdata), 32'h0);
    chk("reset.ram_addr", 32'(ram_addr), 32'h0);
    reset = 1'b0;
    tick();

    // CPU write 0xA to 0x123; address change mid-access must be ignored.
    cpu_req = 1; cpu_we = 1; cpu_addr = 12'h123; cpu_wdata = 4'hA;
    tick();
    chk_bus("wr.c1", 1, 1, 1, 0, 0, 0, 1);
    chk("wr.c1.addr", 32'(ram_addr), 32'h123);
    chk("wr.c1.wdata", 32'(ram_wdata), 32'hA);
    cpu_addr = 12'h777; cpu_wdata = 4'h1;
    tick();
    chk_bus("wr.c2", 1, 1, 1, 0, 0, 0, 1);
    chk("wr.c2.addr", 32'(ram_addr), 32'h123);
    chk("wr.c2.wdata", 32'(ram_wdata), 32'hA);
    tick();
    chk_bus("wr.c3", 0, 0, 0, 0, 1, 0, 1);
    cpu_req = 0;
    tick();
    chk_bus("wr.c4", 0, 0, 0, 0, 0, 0, 0);
    chk("wr.cpu_rdata", 32'(cpu_rdata), 32'h0);

    // CPU read back 0x123.
    cpu_req = 1; cpu_we = 0; cpu_addr = 12'h123;
    tick();
    chk_bus("rd.c1", 1, 0, 1, 0, 0, 0, 1);
    tick();
    tick();
    chk_bus("rd.c3", 0, 0, 0, 0, 1, 0, 1);
    chk("rd.cpu_rdata", 32'(cpu_rdata), 32'hA);
    cpu_req = 0;
    tick();

    // Simultaneous: CPU writes 0x5 to 0x040, debug reads 0x040 afterwards.
    cpu_req = 1; cpu_we = 1; cpu_addr = 12'h040; cpu_wdata = 4'h5;
    dbg_req = 1; dbg_we = 0; dbg_addr = 12'h040;
    tick();
    chk_bus("sim.c1", 1, 1, 1, 0, 0, 0, 1);
    tick();
    tick();
    chk_bus("sim.c3", 0, 0, 0, 0, 1, 0, 1);
    cpu_req = 0;
    tick();
    chk_bus("sim.c4", 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk_bus("sim.c5", 1, 0, 0, 1, 0, 0, 1);
    chk("sim.c5.addr", 32'(ram_addr), 32'h040);
    tick();
    tick();
    chk_bus("sim.c7", 0, 0, 0, 0, 0, 1, 1);
    chk("sim.dbg_rdata", 32'(dbg_rdata), 32'h5);
    chk("sim.cpu_rdata", 32'(cpu_rdata), 32'hA);
    dbg_req = 0;
    tick();

    // Starvation: both held; debug must take the cycle-4 IDLE, CPU regains at 8.
    cpu_req = 1; cpu_we = 1; cpu_addr = 12'h200; cpu_wdata = 4'h3;
    dbg_req = 1; dbg_we = 1; dbg_addr = 12'h300; dbg_wdata = 4'h7;
    tick();
    chk_bus("stv.c1", 1, 1, 1, 0, 0, 0, 1);
    tick();
    tick();
    chk_bus("stv.c3", 0, 0, 0, 0, 1, 0, 1);
    tick();
    chk_bus("stv.c4", 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk_bus("stv.c5", 1, 1, 0, 1, 0, 0, 1);
    chk("stv.c5.addr", 32'(ram_addr), 32'h300);
    chk("stv.c5.wdata", 32'(ram_wdata), 32'h7);
    tick();
    tick();
    chk_bus("stv.c7", 0, 0, 0, 0, 0, 1, 1);
    tick();
    chk_bus("stv.c8", 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk_bus("stv.c9", 1, 1, 1, 0, 0, 0, 1);
    chk("stv.c9.addr", 32'(ram_addr), 32'h200);
    cpu_req = 0; dbg_req = 0;
    tick();
    tick();
    chk_bus("stv.c11", 0, 0, 0, 0, 1, 0, 1);
    tick();
    chk("mem.200", 32'(mem[12'h200]), 32'h3);
    chk("mem.300", 32'(mem[12'h300]), 32'h7);

    // Reset in the second ACCESS cycle of a debug write to 0xFFF.
    dbg_req = 1; dbg_we = 1; dbg_addr = 12'hFFF; dbg_wdata = 4'h9;
    tick();
    chk_bus("rst.c1", 1, 1, 0, 1, 0, 0, 1);
    tick();
    chk_bus("rst.c2", 1, 1, 0, 1, 0, 0, 1);
    reset = 1'b1;
    tick();
    chk_bus("rst.c3", 0, 0, 0, 0, 0, 0, 0);
    chk("rst.cpu_rdata", 32'(cpu_rdata), 32'h0);
    reset = 1'b0; dbg_req = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst.no_done", 32'(dbg_done), 32'h0);
    end

    // Idle: nothing requested for 10 cycles.
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_bus("idle", 0, 0, 0, 0, 0, 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
